// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller sitting behind the ID/EX register. Detects load-use
// hazards, taken branches and multi-cycle data-memory waits, and drives the
// stall / flush / bubble controls for PC, IF/ID, ID/EX and EX/MEM.
//
// Optional feature macro: HAZARD_PERF_EN (builds the performance counters;
// without it the perf_* ports are tied to zero).
//
// Parameters:
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..3)
//   MEM_TIMEOUT        MEM_WAIT cycles before mem_timeout is raised (1..65535)
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   id_rs, id_rt        ID-stage source registers
//   id_uses_rt          ID instruction reads rt
//   ex_memread          EX instruction is a load
//   ex_regrt            EX load destination register
//   ex_branch, ex_zero  EX branch and ALU zero flag (taken when both set)
//   mem_req, mem_ready  data-memory handshake of the MEM stage
//   pc_stall            hold the PC                       (combinational)
//   ifid_stall          hold IF/ID                        (combinational)
//   ifid_flush          zero IF/ID                        (combinational)
//   idex_flush          bubble into ID/EX                 (combinational)
//   exmem_stall         hold EX/MEM                       (combinational)
//   pc_sel_branch       select branch target for the PC   (combinational)
//   mem_timeout         sticky memory timeout error       (registered)
//   perf_*_cnt          saturating performance counters   (registered)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT       = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_regrt,
   input  logic        ex_branch,
   input  logic        ex_zero,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_stall,
   output logic        pc_sel_branch,
   output logic        mem_timeout,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_memwait_cnt
);

   localparam int unsigned WAIT_W = 16;
   localparam int unsigned BUB_W  = 2;
   localparam int unsigned PERF_W = 32;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BUB_W-1:0]    bub_cnt_q, bub_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                timeout_q, timeout_d;

   // internal raw controls, gated by reset before reaching the ports
   logic                mem_stall_c;
   logic                luh_stall_c;
   logic                br_flush_c;

   logic                luh_c;
   logic                tkn_c;
   logic                mw_c;

   // Hazard conditions; register 0 is hard-wired so it never creates a hazard
   assign luh_c = ex_memread && (ex_regrt != 5'd0) &&
                  ((ex_regrt == id_rs) || (id_uses_rt && (ex_regrt == id_rt)));
   assign tkn_c = ex_branch && ex_zero;
   assign mw_c  = mem_req && !mem_ready;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         bub_cnt_q  <= '0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bub_cnt_q  <= bub_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state and raw control decode
   always_comb begin
      state_d     = state_q;
      bub_cnt_d   = bub_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      mem_stall_c = 1'b0;
      luh_stall_c = 1'b0;
      br_flush_c  = 1'b0;

      unique case (state_q)
         RUN: begin
            // priority mw > tkn > luh; a taken branch kills the hazarding instr
            if (mw_c) begin
               mem_stall_c = 1'b1;
               wait_cnt_d  = '0;
               state_d     = MEM_WAIT;
            end else if (tkn_c) begin
               br_flush_c = 1'b1;
            end else if (luh_c) begin
               luh_stall_c = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  bub_cnt_d = BUB_W'(LOAD_STALL_CYCLES - 1);
                  state_d   = LOAD_STALL;
               end
            end
         end

         LOAD_STALL: begin
            // EX holds a bubble here, so branch inputs are meaningless
            if (mw_c) begin
               mem_stall_c = 1'b1;
               wait_cnt_d  = '0;
               bub_cnt_d   = '0;
               state_d     = MEM_WAIT;
            end else begin
               luh_stall_c = 1'b1;
               if (bub_cnt_q <= BUB_W'(1)) begin
                  bub_cnt_d = '0;
                  state_d   = RUN;
               end else begin
                  bub_cnt_d = bub_cnt_q - BUB_W'(1);
               end
            end
         end

         MEM_WAIT: begin
            if (!mem_ready) begin
               mem_stall_c = 1'b1;
               if (wait_cnt_q != '1) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
               if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
                  timeout_d = 1'b1;
               end
            end else begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Reset forces the combinational controls low immediately
   assign pc_stall      = rst & (mem_stall_c | luh_stall_c);
   assign ifid_stall    = rst & (mem_stall_c | luh_stall_c);
   assign ifid_flush    = rst & br_flush_c;
   assign idex_flush    = rst & (br_flush_c | luh_stall_c);
   assign exmem_stall   = rst & mem_stall_c;
   assign pc_sel_branch = rst & br_flush_c;
   assign mem_timeout   = timeout_q;

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] perf_stall_q;
   logic [PERF_W-1:0] perf_flush_q;
   logic [PERF_W-1:0] perf_memwait_q;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
         perf_memwait_q <= '0;
      end else begin
         if (pc_stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + PERF_W'(1);
         end
         if (ifid_flush && (perf_flush_q != '1)) begin
            perf_flush_q <= perf_flush_q + PERF_W'(1);
         end
         if (mem_stall_c && (perf_memwait_q != '1)) begin
            perf_memwait_q <= perf_memwait_q + PERF_W'(1);
         end
      end
   end

   assign perf_stall_cnt   = perf_stall_q;
   assign perf_flush_cnt   = perf_flush_q;
   assign perf_memwait_cnt = perf_memwait_q;
`else
   assign perf_stall_cnt   = '0;
   assign perf_flush_cnt   = '0;
   assign perf_memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// u_dut_a with LOAD_STALL_CYCLES=1, u_dut_b with LOAD_STALL_CYCLES=3, both
// with MEM_TIMEOUT=8. Inputs change 1 time unit after the rising edge and
// outputs are sampled 2 units later, well before the next edge.
// Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush,
//                       exmem_stall, pc_sel_branch, mem_timeout}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] O_NONE = 7'b000_0000;
   localparam logic [6:0] O_LUH  = 7'b110_1000;
   localparam logic [6:0] O_BR   = 7'b001_1010;
   localparam logic [6:0] O_MEM  = 7'b110_0100;
   localparam logic [6:0] O_TO   = 7'b000_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_regrt;
   logic        id_uses_rt, ex_memread, ex_branch, ex_zero, mem_req, mem_ready;

   logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush;
   logic        a_exmem_stall, a_pc_sel, a_timeout;
   logic [31:0] a_perf_stall, a_perf_flush, a_perf_memwait;
   logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush;
   logic        b_exmem_stall, b_pc_sel, b_timeout;
   logic [31:0] b_perf_stall, b_perf_flush, b_perf_memwait;

   logic [6:0]  oa, ob;

   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_regrt(ex_regrt),
      .ex_branch(ex_branch), .ex_zero(ex_zero),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
      .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
      .exmem_stall(a_exmem_stall), .pc_sel_branch(a_pc_sel),
      .mem_timeout(a_timeout),
      .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush),
      .perf_memwait_cnt(a_perf_memwait)
   );

   pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) u_dut_b (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_regrt(ex_regrt),
      .ex_branch(ex_branch), .ex_zero(ex_zero),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
      .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
      .exmem_stall(b_exmem_stall), .pc_sel_branch(b_pc_sel),
      .mem_timeout(b_timeout),
      .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush),
      .perf_memwait_cnt(b_perf_memwait)
   );

   assign oa = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush,
                a_exmem_stall, a_pc_sel, a_timeout};
   assign ob = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush,
                b_exmem_stall, b_pc_sel, b_timeout};

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle, then compare both instances
   task automatic chk2(input string tag, input logic [6:0] ea, input logic [6:0] eb);
      #2;
      check({tag, "_a"}, 32'(oa), 32'(ea));
      check({tag, "_b"}, 32'(ob), 32'(eb));
   endtask

   task automatic clear_in();
      id_rs      = 5'd0;
      id_rt      = 5'd0;
      id_uses_rt = 1'b0;
      ex_memread = 1'b0;
      ex_regrt   = 5'd0;
      ex_branch  = 1'b0;
      ex_zero    = 1'b0;
      mem_req    = 1'b0;
      mem_ready  = 1'b0;
   endtask

   task automatic set_luh(input logic [4:0] rd);
      ex_memread = 1'b1;
      ex_regrt   = rd;
      id_rs      = rd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b0;
      clear_in();

      // reset state
      chk2("reset_outs", O_NONE, O_NONE);
      check("reset_perf_stall", a_perf_stall, 32'd0);
      check("reset_perf_memwait", a_perf_memwait, 32'd0);
      cyc();
      rst = 1'b1;
      chk2("idle", O_NONE, O_NONE);

      // load-use on rs: A stalls 1 cycle, B stalls 3 cycles
      cyc(); set_luh(5'd5);
      chk2("luh_rs_c1", O_LUH, O_LUH);
      cyc(); clear_in();
      chk2("luh_rs_c2", O_NONE, O_LUH);
      cyc();
      chk2("luh_rs_c3", O_NONE, O_LUH);
      cyc();
      chk2("luh_rs_done", O_NONE, O_NONE);

      // ex_regrt = 0 never stalls
      cyc(); ex_memread = 1'b1; ex_regrt = 5'd0; id_rs = 5'd0;
      chk2("luh_r0", O_NONE, O_NONE);

      // rt dependency gated by id_uses_rt
      cyc(); clear_in(); ex_memread = 1'b1; ex_regrt = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
      chk2("rt_unused", O_NONE, O_NONE);
      cyc(); id_uses_rt = 1'b1;
      chk2("rt_used_c1", O_LUH, O_LUH);
      cyc(); clear_in();
      chk2("rt_used_c2", O_NONE, O_LUH);
      cyc();
      chk2("rt_used_c3", O_NONE, O_LUH);
      cyc();
      chk2("rt_used_done", O_NONE, O_NONE);

      // not-taken branch does nothing
      cyc(); ex_branch = 1'b1; ex_zero = 1'b0;
      chk2("br_not_taken", O_NONE, O_NONE);

      // taken branch wins over simultaneous load-use
      cyc(); ex_zero = 1'b1; set_luh(5'd5);
      chk2("br_taken_luh", O_BR, O_BR);
      cyc(); clear_in();
      chk2("br_after", O_NONE, O_NONE);

      // memory wait: 4 cycles not ready (first one also carries a load-use)
      cyc(); mem_req = 1'b1; mem_ready = 1'b0; set_luh(5'd9);
      chk2("mw_c1", O_MEM, O_MEM);
      cyc(); ex_memread = 1'b0;
      chk2("mw_c2", O_MEM, O_MEM);
      cyc();
      chk2("mw_c3", O_MEM, O_MEM);
      cyc();
      chk2("mw_c4", O_MEM, O_MEM);
      cyc(); mem_ready = 1'b1;
      chk2("mw_ready", O_NONE, O_NONE);
`ifdef HAZARD_PERF_EN
      check("perf_memwait_a", a_perf_memwait, 32'd4);
      check("perf_memwait_b", b_perf_memwait, 32'd4);
      check("perf_flush_a", a_perf_flush, 32'd1);
`else
      check("perf_memwait_off", a_perf_memwait, 32'd0);
      check("perf_flush_off", b_perf_flush, 32'd0);
`endif
      cyc(); clear_in();
      chk2("mw_done", O_NONE, O_NONE);

      // memory wait abandons remaining load-use bubbles in B
      cyc(); set_luh(5'd4);
      chk2("ls_abandon_c1", O_LUH, O_LUH);
      cyc(); clear_in(); mem_req = 1'b1;
      chk2("ls_abandon_mw", O_MEM, O_MEM);
      cyc(); mem_ready = 1'b1;
      chk2("ls_abandon_rdy", O_NONE, O_NONE);
      cyc(); clear_in();
      chk2("ls_abandon_done", O_NONE, O_NONE);

      // timeout: mem_ready low for 20 cycles
      for (int c = 1; c <= 20; c++) begin
         cyc(); mem_req = 1'b1; mem_ready = 1'b0;
         if (c == 7)  chk2("to_early", O_MEM, O_MEM);
         if (c == 12) chk2("to_set", O_MEM | O_TO, O_MEM | O_TO);
         if (c == 20) chk2("to_hold", O_MEM | O_TO, O_MEM | O_TO);
      end
      cyc(); mem_ready = 1'b1;
      chk2("to_ready", O_TO, O_TO);
      cyc(); clear_in();
      chk2("to_sticky", O_TO, O_TO);

      // reset in the 2nd LOAD_STALL cycle of B
      cyc(); set_luh(5'd6);
      chk2("rst_ls_c1", O_LUH | O_TO, O_LUH | O_TO);
      cyc(); clear_in();
      chk2("rst_ls_c2", O_TO, O_LUH | O_TO);
      cyc(); rst = 1'b0;
      chk2("rst_mid", O_NONE, O_NONE);
      cyc(); rst = 1'b1;
      chk2("rst_rel_c1", O_NONE, O_NONE);
      cyc();
      chk2("rst_rel_c2", O_NONE, O_NONE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller on the consumer side of the ID/EX register. It reads the EX-stage control fields latched there (`ex_memread`, `ex_regrt`, `ex_branch`) together with the ID-stage source registers and the data-memory handshake. From these it drives the stall, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM. The block resolves three hazards: load-use, taken branch, and multi-cycle data-memory wait.

## Interface
Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard. Legal values 1–3.
- `MEM_TIMEOUT`, default 255: number of MEM_WAIT cycles after which `mem_timeout` is raised. Legal values 1–65535.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_rs`  in  5  ID-stage source register rs.
- `id_rt`  in  5  ID-stage source register rt.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `ex_memread`  in  1  EX instruction is a load (from ID/EX).
- `ex_regrt`  in  5  EX load destination (from ID/EX).
- `ex_branch`  in  1  EX instruction is a branch (from ID/EX).
- `ex_zero`  in  1  ALU zero flag; the branch is taken when `ex_branch` and `ex_zero` are both 1.
- `mem_req`  in  1  MEM stage has a data-memory access in flight.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_stall`  out  1  hold the PC.
- `ifid_stall`  out  1  hold IF/ID.
- `ifid_flush`  out  1  zero IF/ID.
- `idex_flush`  out  1  load ID/EX with all-zero control (bubble).
- `exmem_stall`  out  1  hold EX/MEM.
- `pc_sel_branch`  out  1  select the branch target for the PC.
- `mem_timeout`  out  1  sticky timeout error.
- `perf_stall_cnt`  out  32  performance counter.
- `perf_flush_cnt`  out  32  performance counter.
- `perf_memwait_cnt`  out  32  performance counter.

## Operation
- Load-use hazard (`luh`) condition: `ex_memread` && `ex_regrt` != 0 && (`ex_regrt` == `id_rs` || (`id_uses_rt` && `ex_regrt` == `id_rt`)).
- Taken branch (`tkn`) condition: `ex_branch` && `ex_zero`.
- Memory wait (`mw`) condition: `mem_req` && !`mem_ready`.
- FSM states: RUN, LOAD_STALL, MEM_WAIT. Reset state is RUN.
- RUN evaluates the conditions in priority order mw > tkn > luh:
  - mw: assert `pc_stall`, `ifid_stall`, `exmem_stall`, and also hold ID/EX (no flush). Next state MEM_WAIT. Clear the wait counter.
  - tkn: assert `pc_sel_branch`, `ifid_flush` and `idex_flush` for that cycle only. Remain in RUN.
  - luh: assert `pc_stall`, `ifid_stall` and `idex_flush`. If `LOAD_STALL_CYCLES` > 1, go to LOAD_STALL and load the bubble counter with `LOAD_STALL_CYCLES`-1. Otherwise remain in RUN.
  - none: all outputs 0.
- LOAD_STALL:
  - Hold `pc_stall`, `ifid_stall` and `idex_flush`; decrement the bubble counter.
  - Return to RUN in the cycle the counter reaches 0.
  - If mw occurs, abandon the remaining bubbles and go to MEM_WAIT. RUN re-evaluates luh afterwards.
  - `ex_branch` is ignored, because EX holds a bubble.
- MEM_WAIT:
  - While `mem_ready` = 0, hold the stall set described under mw and increment the wait counter (16-bit, saturating).
  - When the counter equals `MEM_TIMEOUT`, set `mem_timeout`. It stays set until reset.
  - When `mem_ready` = 1, all stalls drop in that same cycle and the next state is RUN.
  - tkn and luh are ignored while in MEM_WAIT.
- `ex_regrt` = 0 never causes a stall.

## Timing
- Stall, flush and select outputs are combinational from the current state and inputs. They have zero latency, so the affected pipeline registers act on the next rising edge.
- State, counters and `mem_timeout` are registered on `clk`.
- While `rst` is low, all outputs are forced to 0, the state is RUN and all counters are 0.
- Reset asserted mid-stall or mid-wait aborts the operation immediately. No stall persists past the reset release.
- A load-use hazard costs exactly `LOAD_STALL_CYCLES` cycles of `pc_stall`.
- A taken branch costs exactly 1 flush cycle.
- A memory wait costs N stall cycles, where N is the number of cycles with `mem_ready` = 0.
- Simultaneous tkn and luh in RUN: only the branch flush occurs, because the hazarding instruction is itself flushed.

## Configuration
- Macro `HAZARD_PERF_EN` enables the performance counters:
  - `perf_stall_cnt` increments on each cycle with `pc_stall` = 1.
  - `perf_flush_cnt` increments on each cycle with `ifid_flush` = 1.
  - `perf_memwait_cnt` increments on each cycle spent in MEM_WAIT with `mem_ready` = 0.
  - All three are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Without the macro, the counter registers are not built and all three `perf_*` ports are tied to 0. Every other behaviour is identical.

## Test plan
- Load-use stall: `ex_memread`=1, `ex_regrt`=5, `id_rs`=5, `LOAD_STALL_CYCLES`=1 -> `pc_stall`, `ifid_stall` and `idex_flush` are high for 1 cycle. With `ex_regrt`=0 instead -> no stall.
- Rt dependency gating: `ex_regrt`=7, `id_rt`=7 and `LOAD_STALL_CYCLES`=3 -> with `id_uses_rt`=1, 3 consecutive stall cycles and then RUN; with `id_uses_rt`=0, no stall.
- Taken branch: `ex_branch`=1 and `ex_zero`=1 together with a luh match -> `pc_sel_branch`, `ifid_flush` and `idex_flush` high for 1 cycle, and `pc_stall` stays 0.
- Memory wait: `mem_req`=1 with `mem_ready` low for 4 cycles, then high -> `pc_stall`, `ifid_stall` and `exmem_stall` high for 4 cycles and low on the `mem_ready` cycle. With `HAZARD_PERF_EN`, `perf_memwait_cnt`=4.
- Timeout: `MEM_TIMEOUT`=8 and `mem_ready` held low for 20 cycles -> `mem_timeout` rises after the 8th wait cycle and stays high after `mem_ready` goes high, until `rst` goes low.
- Reset mid-operation: pull `rst` low in the 2nd cycle of LOAD_STALL (`LOAD_STALL_CYCLES`=3) -> all outputs are 0 immediately and remain 0 after release when no hazard is present.
